// File: rtl/alu_seq_if.sv
// Handshake bus of the multi-cycle ALU: request side (operands/op) and result side.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluout;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, srca, srcb, alucontrol, shamt, out_ready,
    input  in_ready, out_valid, aluout, zero, illegal
  );

  modport slave (
    input  in_valid, srca, srcb, alucontrol, shamt, out_ready,
    output in_ready, out_valid, aluout, zero, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle RV32I ALU: chunked ripple add/sub/compare, bit-serial shifts,
// valid/ready on both sides.
//   state   | meaning
//   S_IDLE  | waiting for a request, in_ready=1
//   S_ARITH | one CHUNK-wide add per cycle through carry_q
//   S_SHIFT | one-bit shift per cycle; single-step ops also pass here once
//   S_DONE  | result held until out_ready
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW    = $clog2(WIDTH);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_ARITH, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [KW-1:0]    k_q;
  logic             carry_q, ill_q, do_shift_q;

  logic             in_ready, out_valid, accept;
  logic             is_arith_in, is_shift_in, legal_in;
  logic [WIDTH-1:0] single_res, b_eff, sum_full, arith_res, shift_res;
  logic [CHUNK-1:0] c_sum;
  logic             c_out, ovf;

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    is_arith_in = 1'b0;
    is_shift_in = 1'b0;
    legal_in    = 1'b1;
    single_res  = '0;
    case (bus.alucontrol)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: is_arith_in = 1'b1;
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift_in = 1'b1;
        single_res  = bus.srca;
      end
      OP_XOR:  single_res = bus.srca ^ bus.srcb;
      OP_OR:   single_res = bus.srca | bus.srcb;
      OP_AND:  single_res = bus.srca & bus.srcb;
      default: legal_in = 1'b0;
    endcase
  end

  // sub/slt/sltu add ~B with carry-in 1 (set at accept)
  always_comb begin
    b_eff = (op_q == OP_ADD) ? b_q : ~b_q;
    {c_out, c_sum} = {1'b0, a_q[int'(k_q)*CHUNK +: CHUNK]}
                   + {1'b0, b_eff[int'(k_q)*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};
    sum_full = res_q;
    sum_full[WIDTH-1 -: CHUNK] = c_sum;
    ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
    case (op_q)
      OP_SLT:  arith_res = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ ovf};
      OP_SLTU: arith_res = {{(WIDTH-1){1'b0}}, ~c_out};
      default: arith_res = sum_full;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_res = res_q << 1;
      OP_SRL:  shift_res = res_q >> 1;
      default: shift_res = {a_q[WIDTH-1], res_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_arith_in ? S_ARITH : S_SHIFT;
      S_ARITH: if (k_q == K_LAST) state_d = S_DONE;
      S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
      default: if (bus.out_ready) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.aluout    = res_q;
  assign bus.zero      = out_valid && (res_q == '0);
  assign bus.illegal   = out_valid && ill_q;

  // Single-step ops take one pass through S_SHIFT with shifting disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      carry_q    <= 1'b0;
      ill_q      <= 1'b0;
      do_shift_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          a_q        <= bus.srca;
          b_q        <= bus.srcb;
          op_q       <= bus.alucontrol;
          k_q        <= '0;
          carry_q    <= (bus.alucontrol != OP_ADD);
          ill_q      <= !legal_in;
          do_shift_q <= is_shift_in && (bus.shamt != '0);
          cnt_q      <= (is_shift_in && (bus.shamt != '0)) ? bus.shamt : SHW'(1);
          res_q      <= single_res;
        end
        S_ARITH: begin
          carry_q <= c_out;
          k_q     <= k_q + KW'(1);
          if (k_q == K_LAST) res_q <= arith_res;
          else res_q[int'(k_q)*CHUNK +: CHUNK] <= c_sum;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q - SHW'(1);
          if (do_shift_q) res_q <= shift_res;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an
// arithmetic reference model.
module tb_alu_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111,
      4'b0001, 4'b0101, 4'b1101: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [4:0] sh);
    case (op)
      4'b0000, 4'b1000, 4'b0010, 4'b0011: return 32 / 4;
      4'b0001, 4'b0101, 4'b1101: return (sh == 0) ? 1 : int'(sh);
      default: return 1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input int hold, input bit pre_ready);
    logic [31:0] exp_res;
    int lat;
    exp_res = ref_result(op, a, b, sh);
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.shamt      = sh;
    bus.in_valid   = 1'b1;
    bus.out_ready  = pre_ready;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.srca       = $urandom;
    bus.srcb       = $urandom;
    bus.alucontrol = 4'($urandom);
    bus.shamt      = 5'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, sh)));
    chk({tag, "_aluout"}, bus.aluout, exp_res);
    chk({tag, "_zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'(ref_illegal(op)));
    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_aluout"}, bus.aluout, exp_res);
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.srca       = '0;
    bus.srcb       = '0;
    bus.alucontrol = '0;
    bus.shamt      = '0;
    bus.out_ready  = 1'b0;
    #23;
    chk("rst_aluout", bus.aluout, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 4'b0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 0, 1'b0);
    run_op("sub", 4'b1000, 32'd5, 32'd7, 5'd0, 1, 1'b0);
    run_op("slt_neg", 4'b0010, 32'h8000_0000, 32'h0000_0001, 5'd0, 0, 1'b1);
    run_op("slt_ovf", 4'b0010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0, 1'b0);
    run_op("sltu", 4'b0011, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0, 1'b0);
    run_op("sra4", 4'b1101, 32'h8000_0000, 32'd0, 5'd4, 0, 1'b0);
    run_op("srl31", 4'b0101, 32'h8000_0000, 32'd0, 5'd31, 0, 1'b0);
    run_op("sll0", 4'b0001, 32'h8000_0000, 32'd0, 5'd0, 0, 1'b0);
    run_op("and_bp", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 3, 1'b0);
    run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0, 1'b0);

    // Abort an add mid-way through the chunk loop
    bus.alucontrol = 4'b0000;
    bus.srca       = 32'h1234_5678;
    bus.srcb       = 32'h1111_1111;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_aluout", bus.aluout, 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 5'd0, 0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      run_op("rand", op, a, b, 5'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
